// File: rtl/router_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// router_pkg
//   Shared definitions for the 1x3 router control slice: FSM state
//   encoding, header field positions and small port-select helpers.
//   Rev 1.0  initial release
// ---------------------------------------------------------------------------
package router_pkg;

   localparam int NUM_PORTS = 3;

   // Address value that does not map to any output port
   localparam logic [1:0] ADDR_INVALID = 2'd3;

   // Header byte layout: [7:2] payload length, [1:0] destination
   localparam int HDR_ADDR_LSB = 0;
   localparam int HDR_ADDR_MSB = 1;
   localparam int HDR_LEN_LSB  = 2;
   localparam int HDR_LEN_MSB  = 7;

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      LOAD_PARITY        = 3'd3,
      CHECK_PARITY_ERROR = 3'd4,
      FIFO_FULL_STATE    = 3'd5,
      LOAD_AFTER_FULL    = 3'd6,
      WAIT_TILL_EMPTY    = 3'd7
   } state_t;

   // Select one per-port flag by 2-bit address; the invalid address reads 0
   function automatic logic port_bit(input logic [NUM_PORTS-1:0] vec,
                                     input logic [1:0]           addr);
      case (addr)
         2'd0:    return vec[0];
         2'd1:    return vec[1];
         2'd2:    return vec[2];
         default: return 1'b0;
      endcase
   endfunction

   // One-hot port strobe for a 2-bit address; the invalid address gives 0
   function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] addr);
      case (addr)
         2'd0:    return 3'b001;
         2'd1:    return 3'b010;
         2'd2:    return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/router_timeout.sv
`default_nettype none
// ---------------------------------------------------------------------------
// router_timeout
//   Idle-read watchdog for one output port. Counts consecutive cycles in
//   which the port holds data that its destination is not reading and
//   issues a one-cycle soft_reset on the TIMEOUT-th such cycle.
//   Rev 1.0  initial release
// ---------------------------------------------------------------------------
module router_timeout #(
   parameter int TIMEOUT = 30
) (
   input  logic clock,
   input  logic resetn,
   input  logic valid,
   input  logic read_enb,
   output logic soft_reset
);

   logic [4:0] cnt;

   // Count unread cycles; a read or an empty FIFO restarts the count, and
   // hitting the terminal count pulses soft_reset and wraps to zero
   always_ff @(posedge clock) begin
      if (!resetn) begin
         cnt        <= 5'd0;
         soft_reset <= 1'b0;
      end else if (!valid || read_enb) begin
         cnt        <= 5'd0;
         soft_reset <= 1'b0;
      end else if (cnt == 5'(TIMEOUT - 1)) begin
         cnt        <= 5'd0;
         soft_reset <= 1'b1;
      end else begin
         cnt        <= cnt + 5'd1;
         soft_reset <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/router_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// router_ctrl
//   Control FSM of the 1x3 router. Decodes the header, sequences writes
//   into the addressed output FIFO, handles full stalls and the parity
//   phase, and aborts the packet when the addressed port is soft-reset.
//   Rev 1.0  initial release
// ---------------------------------------------------------------------------
module router_ctrl
   import router_pkg::*;
#(
   parameter int TIMEOUT = 30,
   parameter int NPORTS  = NUM_PORTS
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              pkt_valid,
   input  logic [7:0]        data_in,
   input  logic [NPORTS-1:0] fifo_full,
   input  logic [NPORTS-1:0] fifo_empty,
   input  logic [NPORTS-1:0] read_enb,
   input  logic              parity_done,
   input  logic              low_pkt_valid,
   output logic [NPORTS-1:0] write_enb,
   output logic              lfd_state,
   output logic              ld_state,
   output logic              laf_state,
   output logic              full_state,
   output logic              detect_add,
   output logic              rst_int_reg,
   output logic              busy,
   output logic [NPORTS-1:0] valid_out,
   output logic [NPORTS-1:0] soft_reset
);

   state_t     state;
   state_t     next_state;
   logic [1:0] addr_q;
   logic [1:0] next_addr;
   logic [1:0] hdr_addr;
   logic       unused_hdr_len;

   assign hdr_addr       = data_in[HDR_ADDR_MSB:HDR_ADDR_LSB];
   // Payload length is tracked by the source, not by this block
   assign unused_hdr_len = ^data_in[HDR_LEN_MSB:HDR_LEN_LSB];

   assign valid_out = ~fifo_empty;

   // One idle-read watchdog per output port
   generate
      for (genvar i = 0; i < NPORTS; i++) begin : g_timeout
         router_timeout #(
            .TIMEOUT    (TIMEOUT)
         ) u_timeout (
            .clock      (clock),
            .resetn     (resetn),
            .valid      (valid_out[i]),
            .read_enb   (read_enb[i]),
            .soft_reset (soft_reset[i])
         );
      end
   endgenerate

   // Next-state and next-address selection; a flush of the active port
   // abandons the packet from any state except address decode
   always_comb begin
      next_state = state;
      next_addr  = addr_q;
      if (state != DECODE_ADDRESS && port_bit(soft_reset, addr_q)) begin
         next_state = DECODE_ADDRESS;
      end else begin
         case (state)
            DECODE_ADDRESS: begin
               if (pkt_valid && hdr_addr != ADDR_INVALID) begin
                  next_addr = hdr_addr;
                  if (port_bit(fifo_empty, hdr_addr))
                     next_state = LOAD_FIRST_DATA;
                  else
                     next_state = WAIT_TILL_EMPTY;
               end
            end
            LOAD_FIRST_DATA: next_state = LOAD_DATA;
            LOAD_DATA: begin
               if (port_bit(fifo_full, addr_q))
                  next_state = FIFO_FULL_STATE;
               else if (!pkt_valid)
                  next_state = LOAD_PARITY;
            end
            LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
               if (port_bit(fifo_full, addr_q))
                  next_state = FIFO_FULL_STATE;
               else
                  next_state = DECODE_ADDRESS;
            end
            FIFO_FULL_STATE: begin
               if (!port_bit(fifo_full, addr_q))
                  next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
               if (parity_done)
                  next_state = DECODE_ADDRESS;
               else if (low_pkt_valid)
                  next_state = LOAD_PARITY;
               else
                  next_state = LOAD_DATA;
            end
            WAIT_TILL_EMPTY: begin
               if (port_bit(fifo_empty, addr_q))
                  next_state = LOAD_FIRST_DATA;
            end
            default: next_state = DECODE_ADDRESS;
         endcase
      end
   end

   // State/address register with Moore outputs registered from the
   // incoming state, so they track the state register cycle for cycle
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state       <= DECODE_ADDRESS;
         addr_q      <= 2'd0;
         write_enb   <= '0;
         lfd_state   <= 1'b0;
         ld_state    <= 1'b0;
         laf_state   <= 1'b0;
         full_state  <= 1'b0;
         detect_add  <= 1'b1;
         rst_int_reg <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= next_state;
         addr_q      <= next_addr;
         write_enb   <= '0;
         lfd_state   <= 1'b0;
         ld_state    <= 1'b0;
         laf_state   <= 1'b0;
         full_state  <= 1'b0;
         detect_add  <= 1'b0;
         rst_int_reg <= 1'b0;
         busy        <= 1'b0;
         case (next_state)
            DECODE_ADDRESS: detect_add <= 1'b1;
            LOAD_FIRST_DATA: begin
               lfd_state <= 1'b1;
               busy      <= 1'b1;
               write_enb <= port_onehot(next_addr);
            end
            LOAD_DATA: begin
               ld_state  <= 1'b1;
               write_enb <= port_onehot(next_addr);
            end
            LOAD_PARITY: begin
               busy      <= 1'b1;
               write_enb <= port_onehot(next_addr);
            end
            CHECK_PARITY_ERROR: begin
               rst_int_reg <= 1'b1;
               busy        <= 1'b1;
            end
            FIFO_FULL_STATE: begin
               full_state <= 1'b1;
               busy       <= 1'b1;
            end
            LOAD_AFTER_FULL: begin
               laf_state <= 1'b1;
               busy      <= 1'b1;
               write_enb <= port_onehot(next_addr);
            end
            WAIT_TILL_EMPTY: busy <= 1'b1;
            default: detect_add <= 1'b1;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_router_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_router_ctrl
//   Directed self-checking bench for router_ctrl. Control outputs are
//   packed as {write_enb, lfd, ld, laf, full, detect_add, rst_int, busy}.
//   Rev 1.0  initial release
// ---------------------------------------------------------------------------
module tb_router_ctrl;

   logic       clock;
   logic       resetn;
   logic       pkt_valid;
   logic [7:0] data_in;
   logic [2:0] fifo_full;
   logic [2:0] fifo_empty;
   logic [2:0] read_enb;
   logic       parity_done;
   logic       low_pkt_valid;
   logic [2:0] write_enb;
   logic       lfd_state;
   logic       ld_state;
   logic       laf_state;
   logic       full_state;
   logic       detect_add;
   logic       rst_int_reg;
   logic       busy;
   logic [2:0] valid_out;
   logic [2:0] soft_reset;

   logic [9:0] obs;
   int         n_checks;
   int         n_pass;
   logic [2:0] sr_seen;

   // Expected packed flags: {we[2:0], lfd, ld, laf, full, det, rst_int, busy}
   localparam logic [9:0] F_DECODE   = 10'b000_0000100;
   localparam logic [9:0] F_LFD_A1   = 10'b010_1000001;
   localparam logic [9:0] F_LD_A1    = 10'b010_0100000;
   localparam logic [9:0] F_LP_A1    = 10'b010_0000001;
   localparam logic [9:0] F_CPE      = 10'b000_0000011;
   localparam logic [9:0] F_WAIT     = 10'b000_0000001;
   localparam logic [9:0] F_LFD_A2   = 10'b100_1000001;
   localparam logic [9:0] F_LD_A2    = 10'b100_0100000;
   localparam logic [9:0] F_LFD_A0   = 10'b001_1000001;
   localparam logic [9:0] F_LD_A0    = 10'b001_0100000;
   localparam logic [9:0] F_FULL     = 10'b000_0001001;
   localparam logic [9:0] F_LAF_A0   = 10'b001_0010001;
   localparam logic [9:0] F_LP_A0    = 10'b001_0000001;

   assign obs = {write_enb, lfd_state, ld_state, laf_state, full_state,
                 detect_add, rst_int_reg, busy};

   router_ctrl #(
      .TIMEOUT       (30),
      .NPORTS        (3)
   ) dut (
      .clock         (clock),
      .resetn        (resetn),
      .pkt_valid     (pkt_valid),
      .data_in       (data_in),
      .fifo_full     (fifo_full),
      .fifo_empty    (fifo_empty),
      .read_enb      (read_enb),
      .parity_done   (parity_done),
      .low_pkt_valid (low_pkt_valid),
      .write_enb     (write_enb),
      .lfd_state     (lfd_state),
      .ld_state      (ld_state),
      .laf_state     (laf_state),
      .full_state    (full_state),
      .detect_add    (detect_add),
      .rst_int_reg   (rst_int_reg),
      .busy          (busy),
      .valid_out     (valid_out),
      .soft_reset    (soft_reset)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   // Advance one clock and sample just after the edge
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      n_checks      = 0;
      n_pass        = 0;
      resetn        = 1'b0;
      pkt_valid     = 1'b0;
      data_in       = 8'h00;
      fifo_full     = 3'b000;
      fifo_empty    = 3'b111;
      read_enb      = 3'b000;
      parity_done   = 1'b0;
      low_pkt_valid = 1'b0;
      step();
      step();
      check("reset_flags", 32'(obs), 32'(F_DECODE));
      check("reset_valid_out", 32'(valid_out), 32'h0);
      check("reset_soft_reset", 32'(soft_reset), 32'h0);
      resetn = 1'b1;

      // Normal packet: header 0x05 -> port 1, one payload byte, parity
      pkt_valid = 1'b1; data_in = 8'h05; step();
      check("p1_lfd", 32'(obs), 32'(F_LFD_A1));
      data_in = 8'hA5; step();
      check("p1_ld", 32'(obs), 32'(F_LD_A1));
      pkt_valid = 1'b0; data_in = 8'h3C; step();
      check("p1_lp", 32'(obs), 32'(F_LP_A1));
      step();
      check("p1_cpe", 32'(obs), 32'(F_CPE));
      step();
      check("p1_decode", 32'(obs), 32'(F_DECODE));

      // Address 3 is dropped
      pkt_valid = 1'b1; data_in = 8'h07; step();
      check("addr3_stay", 32'(obs), 32'(F_DECODE));
      pkt_valid = 1'b0; step();

      // Port 2 busy: wait until it drains
      fifo_empty = 3'b011; pkt_valid = 1'b1; data_in = 8'h0A; step();
      check("p2_wait", 32'(obs), 32'(F_WAIT));
      check("p2_valid_out", 32'(valid_out), 32'h4);
      step();
      check("p2_wait_hold", 32'(obs), 32'(F_WAIT));
      fifo_empty = 3'b111; step();
      check("p2_lfd", 32'(obs), 32'(F_LFD_A2));
      data_in = 8'h11; step();
      check("p2_ld", 32'(obs), 32'(F_LD_A2));
      pkt_valid = 1'b0; step(); step(); step();
      check("p2_done", 32'(obs), 32'(F_DECODE));

      // Full stall on port 0, resume via low_pkt_valid
      pkt_valid = 1'b1; data_in = 8'h04; step();
      check("p0_lfd", 32'(obs), 32'(F_LFD_A0));
      data_in = 8'h22; step();
      check("p0_ld", 32'(obs), 32'(F_LD_A0));
      fifo_full = 3'b001; step();
      check("p0_full", 32'(obs), 32'(F_FULL));
      step();
      check("p0_full_hold", 32'(obs), 32'(F_FULL));
      fifo_full = 3'b000; pkt_valid = 1'b0; low_pkt_valid = 1'b1; step();
      check("p0_laf", 32'(obs), 32'(F_LAF_A0));
      step();
      check("p0_lp", 32'(obs), 32'(F_LP_A0));
      low_pkt_valid = 1'b0; step();
      check("p0_cpe", 32'(obs), 32'(F_CPE));
      step();
      check("p0_decode", 32'(obs), 32'(F_DECODE));

      // Timeout on idle port 1: pulse on the 30th unread cycle only
      fifo_empty = 3'b101; sr_seen = 3'b000;
      for (int i = 0; i < 29; i++) begin
         step();
         sr_seen |= soft_reset;
      end
      check("to_no_early", 32'(sr_seen), 32'h0);
      step();
      check("to_pulse", 32'(soft_reset), 32'h2);
      step();
      check("to_one_cycle", 32'(soft_reset), 32'h0);
      check("to_fsm_idle", 32'(obs), 32'(F_DECODE));
      // Restart count, then read on the terminal cycle
      fifo_empty = 3'b111; step();
      fifo_empty = 3'b101; sr_seen = 3'b000;
      for (int i = 0; i < 29; i++) begin
         step();
         sr_seen |= soft_reset;
      end
      read_enb = 3'b010; step();
      sr_seen |= soft_reset;
      read_enb = 3'b000; step();
      sr_seen |= soft_reset;
      check("to_read_suppress", 32'(sr_seen), 32'h0);
      fifo_empty = 3'b111; step();

      // Timeout on the active port aborts the packet
      pkt_valid = 1'b1; data_in = 8'h05; step();
      check("ab_lfd", 32'(obs), 32'(F_LFD_A1));
      fifo_empty = 3'b101; data_in = 8'h33; step();
      sr_seen = 3'b000;
      for (int i = 0; i < 28; i++) begin
         step();
         sr_seen |= soft_reset;
      end
      check("ab_no_early", 32'(sr_seen), 32'h0);
      step();
      check("ab_pulse", 32'(soft_reset), 32'h2);
      check("ab_still_ld", 32'(obs), 32'(F_LD_A1));
      pkt_valid = 1'b0; step();
      check("ab_decode", 32'(obs), 32'(F_DECODE));
      fifo_empty = 3'b111; step();

      // Reset mid-packet, then timeout counts from zero
      pkt_valid = 1'b1; data_in = 8'h05; step();
      fifo_empty = 3'b101; data_in = 8'h44; step();
      for (int i = 0; i < 10; i++) step();
      check("rst_pre_ld", 32'(obs), 32'(F_LD_A1));
      resetn = 1'b0; pkt_valid = 1'b0; step();
      check("rst_flags", 32'(obs), 32'(F_DECODE));
      check("rst_soft_reset", 32'(soft_reset), 32'h0);
      resetn = 1'b1; sr_seen = 3'b000;
      for (int i = 0; i < 29; i++) begin
         step();
         sr_seen |= soft_reset;
      end
      check("rst_cnt_cleared", 32'(sr_seen), 32'h0);
      step();
      check("rst_cnt_pulse", 32'(soft_reset), 32'h2);
      fifo_empty = 3'b111; step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
